// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^M) multiplier family: the default AES
// reduction polynomial, the controller state encoding and the xtime helper.
package gf_pkg;

    // Widest field the shared helpers can handle; operands are zero-extended to it.
    localparam int GF_MAX_W = 64;

    // Low byte of x^8 + x^4 + x^3 + x + 1.
    localparam logic [7:0] GF8_AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } gf_mult_state_t;

    // Multiply by x modulo the field polynomial for an m-bit field.
    // The reduction term is AND-gated by the MSB rather than muxed, so the
    // logic structure does not depend on operand values.
    function automatic logic [GF_MAX_W-1:0] gf_xtime(
        input logic [GF_MAX_W-1:0] x,
        input logic [GF_MAX_W-1:0] poly,
        input int                  m
    );
        logic [GF_MAX_W-1:0] mask_v;
        logic [GF_MAX_W-1:0] msb_v;
        mask_v = {GF_MAX_W{1'b1}} >> (GF_MAX_W - m);
        msb_v  = {GF_MAX_W{x[m-1]}};
        return ((x << 1) & mask_v) ^ (poly & msb_v & mask_v);
    endfunction

endpackage

// File: rtl/gf_digit_step.sv
// One digit-serial step of a GF(2^M) shift-and-add multiplier: consumes
// DIGIT multiplier bits, MSB first, folding each into the accumulator via
// acc = xtime(acc) ^ (bit ? a : 0). Purely combinational.
module gf_digit_step
    import gf_pkg::*;
#(
    parameter int              M     = 8,
    parameter logic [M-1:0]    POLY  = GF8_AES_POLY,
    parameter int              DIGIT = 1
) (
    input  logic [M-1:0]     acc,
    input  logic [M-1:0]     a,
    input  logic [DIGIT-1:0] b_digit,
    output logic [M-1:0]     acc_next
);

    logic [GF_MAX_W-1:0] step_s;
    logic [GF_MAX_W-1:0] a_w_s;
    logic [GF_MAX_W-1:0] poly_w_s;

    // Unrolled Horner evaluation over the DIGIT bits of this slice.
    always_comb begin
        a_w_s             = {GF_MAX_W{1'b0}};
        a_w_s[M-1:0]      = a;
        poly_w_s          = {GF_MAX_W{1'b0}};
        poly_w_s[M-1:0]   = POLY;
        step_s            = {GF_MAX_W{1'b0}};
        step_s[M-1:0]     = acc;
        for (int i = DIGIT - 1; i >= 0; i--) begin
            step_s = gf_xtime(step_s, poly_w_s, M) ^ (a_w_s & {GF_MAX_W{b_digit[i]}});
        end
        acc_next = step_s[M-1:0];
    end

endmodule

// File: rtl/gf_mult_ds.sv
// Digit-serial GF(2^M) multiplier with valid/ready handshakes on both sides.
// p_out = f_in * p_in mod P(x); fixed latency of M/DIGIT cycles regardless
// of operand values.
// Optional build macro GF_MULT_DS_PERF_EN adds op_count and busy_cycles
// performance counters as extra output ports.
module gf_mult_ds
    import gf_pkg::*;
#(
    parameter int           M     = 8,
    parameter logic [M-1:0] POLY  = GF8_AES_POLY,
    parameter int           DIGIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] f_in,
    input  logic [M-1:0] p_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] p_out
`ifdef GF_MULT_DS_PERF_EN
    ,
    output logic [31:0]  op_count,
    output logic [31:0]  busy_cycles
`endif
);

    localparam int N     = (DIGIT > 0) ? (M / DIGIT) : 1;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    // Reject illegal digit sizes and oversize fields at elaboration.
    if (DIGIT < 1 || DIGIT > M || (M % DIGIT) != 0) begin : g_bad_digit
        $error("gf_mult_ds: DIGIT must be in 1..M and divide M");
    end
    if (M < 1 || M > GF_MAX_W) begin : g_bad_width
        $error("gf_mult_ds: M out of supported range");
    end

    gf_mult_state_t state_r;
    gf_mult_state_t state_n;

    logic             in_ready_r;
    logic             out_valid_r;
    logic [M-1:0]     p_out_r;
    logic [M-1:0]     a_r;
    logic [M-1:0]     b_r;
    logic [M-1:0]     acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [M-1:0]     acc_next_s;
    logic             accept_s;
    logic             last_s;
    logic             release_s;

    gf_digit_step #(
        .M     (M),
        .POLY  (POLY),
        .DIGIT (DIGIT)
    ) u_step (
        .acc      (acc_r),
        .a        (a_r),
        .b_digit  (b_r[M-1 -: DIGIT]),
        .acc_next (acc_next_s)
    );

    // Next-state and control strobes for the IDLE/BUSY/DONE controller.
    always_comb begin
        state_n   = state_r;
        accept_s  = 1'b0;
        last_s    = 1'b0;
        release_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept_s = 1'b1;
                    state_n  = BUSY;
                end else begin
                    state_n  = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == CNT_LAST) begin
                    last_s  = 1'b1;
                    state_n = DONE;
                end else begin
                    state_n = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    release_s = 1'b1;
                    state_n   = IDLE;
                end else begin
                    state_n   = DONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register; in_ready is registered alongside so it tracks IDLE exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_n;
            in_ready_r <= (state_n == IDLE);
        end
    end

    // Operand capture and one digit of accumulation per BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {M{1'b0}};
            b_r     <= {M{1'b0}};
            acc_r   <= {M{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            p_out_r <= {M{1'b0}};
        end else if (accept_s) begin
            a_r   <= f_in;
            b_r   <= p_in;
            acc_r <= {M{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == BUSY) begin
            acc_r <= acc_next_s;
            b_r   <= b_r << DIGIT;
            cnt_r <= cnt_r + CNT_W'(1);
            if (last_s) begin
                p_out_r <= acc_next_s;
            end
        end
    end

    // Result-valid flag: raised with the final digit, dropped on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
        end else if (last_s) begin
            out_valid_r <= 1'b1;
        end else if (release_s) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign p_out     = p_out_r;

`ifdef GF_MULT_DS_PERF_EN
    logic [31:0] op_count_r;
    logic [31:0] busy_cycles_r;

    // Completed-handshake and BUSY-cycle counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_r    <= 32'd0;
            busy_cycles_r <= 32'd0;
        end else begin
            if (out_valid_r && out_ready) begin
                op_count_r <= op_count_r + 32'd1;
            end
            if (state_r == BUSY) begin
                busy_cycles_r <= busy_cycles_r + 32'd1;
            end
        end
    end

    assign op_count    = op_count_r;
    assign busy_cycles = busy_cycles_r;
`endif

endmodule

// File: tb/tb_gf_mult_ds.sv
// Self-checking bench for gf_mult_ds: directed products, randomized
// operands with handshake noise, backpressure, and reset mid-operation.
module tb_gf_mult_ds;

    parameter int TB_DIGIT = 1;
    localparam int M = 8;
    localparam int N = M / TB_DIGIT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] f_in = 8'h00;
    logic [7:0] p_in = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] p_out;
`ifdef GF_MULT_DS_PERF_EN
    logic [31:0] op_count;
    logic [31:0] busy_cycles;
`endif

    int errors = 0;
    int checks = 0;

    gf_mult_ds #(
        .M     (M),
        .POLY  (8'h1B),
        .DIGIT (TB_DIGIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .f_in      (f_in),
        .p_in      (p_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p_out     (p_out)
`ifdef GF_MULT_DS_PERF_EN
        ,
        .op_count    (op_count),
        .busy_cycles (busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Reference: schoolbook LSB-first multiply in GF(2^8) with plain integers.
    function automatic int gf_ref(input int f, input int p);
        int a;
        int r;
        a = f;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if (((p >> i) & 1) != 0) r = r ^ a;
            a = a << 1;
            if ((a & 'h100) != 0) a = a ^ 'h11B;
        end
        return r & 'hFF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Present operands, wait for acceptance and for the result; returns the
    // product and the number of edges from the accept edge to out_valid.
    // Entered and left #1 after a rising edge.
    task automatic issue(input logic [7:0] f, input logic [7:0] p, input bit noise,
                         output logic [7:0] res, output int lat);
        int  waitc;
        bit  busy_rdy_bad;
        in_valid = 1'b1;
        f_in     = f;
        p_in     = p;
        waitc    = 0;
        while (in_ready !== 1'b1 && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (in_ready !== 1'b1) check_eq("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise) begin
            f_in = 8'($urandom);
            p_in = 8'($urandom);
        end
        lat = 0;
        busy_rdy_bad = 1'b0;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) busy_rdy_bad = 1'b1;
            if (noise) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (out_valid !== 1'b1) check_eq("result_timeout", {31'd0, out_valid}, 32'd1);
        check_eq("busy_in_ready_low", {31'd0, busy_rdy_bad}, 32'd0);
        res = p_out;
    endtask

    // Hold backpressure for gap cycles, verifying stability, then hand off.
    task automatic release_out(input int gap);
        logic [7:0] held;
        bit         unstable;
        held     = p_out;
        unstable = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            if (p_out !== held || out_valid !== 1'b1 || in_ready !== 1'b0) unstable = 1'b1;
        end
        if (gap > 0) check_eq("backpressure_stable", {31'd0, unstable}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("release_valid_low", {31'd0, out_valid}, 32'd0);
        check_eq("release_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("release_p_out_kept", {24'd0, p_out}, {24'd0, held});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] res;
        logic [7:0] f;
        logic [7:0] p;
        int         lat;
        bit         spurious;

        #2 rst_n = 1'b0;
        #1;
        check_eq("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("reset_p_out", {24'd0, p_out}, 32'd0);
        check_eq("reset_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        issue(8'h57, 8'h83, 1'b0, res, lat);
        check_eq("basic_57x83", {24'd0, res}, 32'h0000_00C1);
        check_eq("basic_latency", lat, N);
        release_out(0);

        issue(8'h57, 8'h13, 1'b0, res, lat);
        check_eq("basic_57x13", {24'd0, res}, 32'h0000_00FE);
        check_eq("latency_57x13", lat, N);
        release_out(1);

        p = 8'($urandom_range(1, 255));
        issue(8'h00, p, 1'b0, res, lat);
        check_eq("zero_f", {24'd0, res}, 32'd0);
        check_eq("zero_f_latency", lat, N);
        release_out(0);

        f = 8'($urandom_range(1, 255));
        issue(f, 8'h00, 1'b0, res, lat);
        check_eq("zero_p", {24'd0, res}, 32'd0);
        check_eq("zero_p_latency", lat, N);
        release_out(0);

        issue(8'h01, p, 1'b0, res, lat);
        check_eq("one_f", {24'd0, res}, {24'd0, p});
        check_eq("one_f_latency", lat, N);
        release_out(0);

        issue(f, 8'h01, 1'b0, res, lat);
        check_eq("one_p", {24'd0, res}, {24'd0, f});
        release_out(0);

        for (int k = 0; k < 150; k++) begin
            repeat ($urandom_range(0, 2)) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            out_ready = 1'b0;
            f = 8'($urandom);
            p = 8'($urandom);
            issue(f, p, 1'b1, res, lat);
            check_eq("rand_product", {24'd0, res}, gf_ref(int'(f), int'(p)));
            check_eq("rand_latency", lat, N);
            release_out($urandom_range(0, 3));
        end

        issue(8'hC3, 8'h5A, 1'b0, res, lat);
        check_eq("bp_product", {24'd0, res}, gf_ref('hC3, 'h5A));
        release_out(20);
        issue(8'h0E, 8'hB9, 1'b0, res, lat);
        check_eq("after_bp_product", {24'd0, res}, gf_ref('h0E, 'hB9));
        check_eq("after_bp_latency", lat, N);
        release_out(0);

        in_valid = 1'b1;
        f_in     = 8'h35;
        p_in     = 8'hAB;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midop_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("midop_p_out", {24'd0, p_out}, 32'd0);
        check_eq("midop_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk) rst_n = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) spurious = 1'b1;
        end
        check_eq("no_spurious_after_reset", {31'd0, spurious}, 32'd0);
        issue(8'h02, 8'h80, 1'b0, res, lat);
        check_eq("post_reset_02x80", {24'd0, res}, 32'h0000_001B);
        release_out(0);

`ifdef GF_MULT_DS_PERF_EN
        for (int k = 0; k < 4; k++) begin
            f = 8'($urandom);
            p = 8'($urandom);
            issue(f, p, 1'b0, res, lat);
            check_eq("perf_product", {24'd0, res}, gf_ref(int'(f), int'(p)));
            release_out($urandom_range(0, 2));
        end
        check_eq("perf_op_count", op_count, 32'd5);
        check_eq("perf_busy_cycles", busy_cycles, 5 * N);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
